// File: rtl/id_branch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// id_branch_unit : IF/ID register plus ID-stage beq/bne/j/jal/jr resolution
// Revision       : 1.0
// ============================================================================
module id_branch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      PC,
  input  logic [31:0]      instr_if,
  input  logic             stall,
  input  logic [31:0]      rs_val,
  input  logic [31:0]      rt_val,
  output logic             Jumpsign,
  output logic [31:0]      JumpAddr,
  output logic [31:0]      instr_id,
  output logic [31:0]      pc_id,
  output logic [31:0]      link_id,
  output logic             ds_id,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] FN_JR      = 6'b001000;

  logic [31:0]      instr_q, instr_d;
  logic [31:0]      pc_q, pc_d;
  logic             ds_q, ds_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [31:0] pc_plus4;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic        is_ctrl;
  logic        taken;
  logic [31:0] target;

  assign op        = instr_q[31:26];
  assign funct     = instr_q[5:0];
  assign pc_plus4  = pc_q + 32'd4;
  assign br_target = pc_plus4 + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
  assign j_target  = {pc_plus4[31:28], instr_q[25:0], 2'b00};

  // Decode and resolve; the default target keeps JumpAddr deterministic
  // even when no transfer is in ID.
  always_comb begin
    is_ctrl = 1'b0;
    taken   = 1'b0;
    target  = pc_plus4;
    case (op)
      OP_BEQ: begin
        is_ctrl = 1'b1;
        taken   = (rs_val == rt_val);
        target  = br_target;
      end
      OP_BNE: begin
        is_ctrl = 1'b1;
        taken   = (rs_val != rt_val);
        target  = br_target;
      end
      OP_J, OP_JAL: begin
        is_ctrl = 1'b1;
        taken   = 1'b1;
        target  = j_target;
      end
      OP_SPECIAL: begin
        if (funct == FN_JR) begin
          is_ctrl = 1'b1;
          taken   = 1'b1;
          target  = rs_val;
        end
      end
      default: ;
    endcase
  end

  assign Jumpsign = taken & ~stall;
  assign JumpAddr = target;

  // The fetch word following any transfer is its delay slot; nothing is flushed.
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    ds_d    = ds_q;
    cnt_d   = cnt_q;
    if (!stall) begin
      instr_d = instr_if;
      pc_d    = PC;
      ds_d    = is_ctrl;
    end
    if (Jumpsign) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= 32'd0;
      pc_q    <= RESET_PC;
      ds_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      ds_q    <= ds_d;
      cnt_q   <= cnt_d;
    end
  end

  assign instr_id  = instr_q;
  assign pc_id     = pc_q;
  assign ds_id     = ds_q;
  assign taken_cnt = cnt_q;
  assign link_id   = pc_q + 32'd8;

endmodule
`default_nettype wire

// File: tb/tb_id_branch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_id_branch_unit : directed + randomized checks against a behavioural model
// Revision          : 1.0
// ============================================================================
module tb_id_branch_unit;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset, stall;
  logic [31:0]   PC, instr_if, rs_val, rt_val;
  logic          Jumpsign, ds_id;
  logic [31:0]   JumpAddr, instr_id, pc_id, link_id;
  logic [CW-1:0] taken_cnt;

  id_branch_unit #(.RESET_PC(32'h0000_3000), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .PC(PC), .instr_if(instr_if), .stall(stall),
    .rs_val(rs_val), .rt_val(rt_val), .Jumpsign(Jumpsign), .JumpAddr(JumpAddr),
    .instr_id(instr_id), .pc_id(pc_id), .link_id(link_id), .ds_id(ds_id),
    .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference state: what the IF/ID register should hold
  logic [31:0] m_pc, m_instr;
  logic        m_ds;
  int unsigned m_cnt;
  bit          m_valid = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_xfer(input logic [31:0] ins);
    int unsigned op = ins >> 26;
    case (op)
      2, 3, 4, 5: return 1'b1;
      0:          return (ins & 32'h3F) == 32'h08;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic bit ref_taken(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
    int unsigned op = ins >> 26;
    if (op == 4) return rs == rt;
    if (op == 5) return rs != rt;
    return ref_xfer(ins);
  endfunction

  function automatic logic [31:0] ref_target(input logic [31:0] pc, input logic [31:0] ins,
                                             input logic [31:0] rs);
    int unsigned       op  = ins >> 26;
    logic signed [31:0] off = $signed(ins[15:0]);
    if (op == 4 || op == 5) return pc + 32'd4 + off * 4;
    if (op == 2 || op == 3) return ((pc + 32'd4) & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 4);
    return rs;
  endfunction

  // One clock: drive inputs, check combinational outputs, clock, check state.
  task automatic step(input bit rst, input bit stl, input logic [31:0] pc, input logic [31:0] ins,
                      input logic [31:0] rs, input logic [31:0] rt);
    bit tk;
    reset = rst; stall = stl; PC = pc; instr_if = ins; rs_val = rs; rt_val = rt;
    #1;
    tk = m_valid && !stl && ref_taken(m_instr, rs, rt);
    if (m_valid) begin
      chk("Jumpsign", 32'(Jumpsign), 32'(tk));
      if (tk) chk("JumpAddr", JumpAddr, ref_target(m_pc, m_instr, rs));
      chk("link_id", link_id, m_pc + 32'd8);
    end
    @(posedge clk);
    if (rst) begin
      m_instr = 32'd0; m_pc = 32'h0000_3000; m_ds = 1'b0; m_cnt = 0; m_valid = 1'b1;
    end else if (m_valid) begin
      if (tk) m_cnt = (m_cnt + 1) % (1 << CW);
      if (!stl) begin
        m_ds    = ref_xfer(m_instr);
        m_instr = ins;
        m_pc    = pc;
      end
    end
    #1;
    if (m_valid) begin
      chk("instr_id", instr_id, m_instr);
      chk("pc_id", pc_id, m_pc);
      chk("ds_id", 32'(ds_id), 32'(m_ds));
      chk("taken_cnt", 32'(taken_cnt), 32'(m_cnt));
    end
  endtask

  initial begin
    int unsigned cnt0;
    logic [31:0] r, ins;
    reset = 1'b1; stall = 1'b1; PC = '0; instr_if = '0; rs_val = '0; rt_val = '0;

    // Reset held two cycles with stall asserted
    step(1, 1, 32'h0, 32'h0, 0, 0);
    step(1, 1, 32'h0, 32'h0, 0, 0);
    chk("rst_instr", instr_id, 32'h0);
    chk("rst_pc", pc_id, 32'h0000_3000);
    chk("rst_ds", 32'(ds_id), 32'h0);
    chk("rst_cnt", 32'(taken_cnt), 32'h0);
    chk("rst_js", 32'(Jumpsign), 32'h0);

    // beq taken, delay slot is jal
    step(0, 0, 32'h3004, 32'h1085_0003, 0, 0);
    rs_val = 32'd5; rt_val = 32'd5; stall = 1'b0; #1;
    chk("beq_js", 32'(Jumpsign), 32'h1);
    chk("beq_addr", JumpAddr, 32'h0000_3014);
    step(0, 0, 32'h3008, 32'h0C00_0C10, 5, 5);
    chk("beq_cnt", 32'(taken_cnt), 32'h1);
    chk("beq_ds", 32'(ds_id), 32'h1);
    chk("jal_addr", JumpAddr, 32'h0000_3040);
    chk("jal_link", link_id, 32'h0000_3010);

    // bne not taken sits in jal's slot; jr sits in bne's slot
    step(0, 0, 32'h300C, 32'h1485_0003, 0, 0);
    step(0, 0, 32'h3010, 32'h03E0_0008, 7, 7);
    chk("bne_cnt", 32'(taken_cnt), 32'h2);
    chk("bne_ds", 32'(ds_id), 32'h1);
    rs_val = 32'h3010; #1;
    chk("jr_addr", JumpAddr, 32'h0000_3010);
    step(0, 0, 32'h3014, 32'h0, 32'h3010, 0);

    // Stall with a taken beq in ID
    step(0, 0, 32'h3020, 32'h1085_0003, 0, 0);
    cnt0 = m_cnt;
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 32'h3024, $urandom, 9, 9);
      chk("stall_js", 32'(Jumpsign), 32'h0);
      chk("stall_instr", instr_id, 32'h1085_0003);
    end
    step(0, 0, 32'h3024, 32'h0, 9, 9);
    chk("stall_cnt", 32'(taken_cnt), 32'((cnt0 + 1) % 16));
    chk("stall_after_js", 32'(Jumpsign), 32'h0);

    // Reset and stall together with a branch in ID
    step(0, 0, 32'h3030, 32'h1000_0004, 0, 0);
    step(1, 1, 32'h3034, 32'h0, 0, 0);
    chk("rstst_instr", instr_id, 32'h0);
    chk("rstst_js", 32'(Jumpsign), 32'h0);

    // Sixteen taken jumps wrap the 4-bit counter back to zero
    for (int i = 0; i < 17; i++) step(0, 0, 32'h4000 + 32'(4 * i), 32'h0800_0400, 0, 0);
    chk("wrap_cnt", 32'(taken_cnt), 32'h0);

    // link wraps at 2^32
    step(0, 0, 32'hFFFF_FFFC, 32'h0, 0, 0);
    chk("link_wrap", link_id, 32'h0000_0004);

    // Randomized mix of transfers, non-transfers, stalls and rare resets
    for (int i = 0; i < 300; i++) begin
      r = $urandom;
      case ($urandom_range(0, 7))
        0:       ins = (32'd4 << 26) | (r & 32'h03FF_FFFF);
        1:       ins = (32'd5 << 26) | (r & 32'h03FF_FFFF);
        2:       ins = (32'd2 << 26) | (r & 32'h03FF_FFFF);
        3:       ins = (32'd3 << 26) | (r & 32'h03FF_FFFF);
        4:       ins = (r & 32'h03FF_FFC0) | 32'h08;
        5:       ins = (r & 32'h03FF_FFC0) | 32'h20;
        default: ins = r;
      endcase
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0), $urandom & 32'hFFFF_FFFC,
           ins, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/id_branch_unit.md
# id_branch_unit

Decode-stage control-transfer unit for the pipelined MIPS core. It holds the IF/ID pipeline register, which captures the fetch-stage PC and instruction word, and resolves beq/bne/j/jal/jr in ID. It drives the redirect pair `Jumpsign`/`JumpAddr` back into the PC register, which makes it the consuming end of the PC's fetch-address interface. It implements MIPS delay-slot semantics: the slot instruction is never flushed. It also tracks the delay-slot flag, the link value and a taken-transfer counter.

## Interface
- `RESET_PC`, default 32'h0000_3000: value of `pc_id` after reset.
- `CNT_W`, default 16: width of `taken_cnt`.

Ports:
- `clk` in 1: the single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high; takes effect on the rising edge of `clk` while high.
- `PC` in 32: fetch address from the PC register (IF stage).
- `instr_if` in 32: instruction word read at `PC`.
- `stall` in 1: hazard-unit stall; holds IF/ID and suppresses redirect.
- `rs_val` in 32: forwarded GPR[rs] for the instruction in ID.
- `rt_val` in 32: forwarded GPR[rt] for the instruction in ID.
- `Jumpsign` out 1: redirect request to the PC register.
- `JumpAddr` out 32: redirect target.
- `instr_id` out 32: IF/ID instruction.
- `pc_id` out 32: IF/ID PC.
- `link_id` out 32: `pc_id + 8` (jal return address).
- `ds_id` out 1: the instruction in ID is a delay slot.
- `taken_cnt` out CNT_W: count of control transfers taken.

## Operation
- IF/ID register:
  - On `reset`: `instr_id`=0 (nop), `pc_id`=RESET_PC, `ds_id`=0, `taken_cnt`=0.
  - Else if `stall`=1: all state holds.
  - Else: `instr_id`←`instr_if`, `pc_id`←`PC`, and `ds_id`←1 when the outgoing `instr_id` is a control transfer (taken or not), otherwise 0.
- Decode on `instr_id` (op = [31:26], funct = [5:0]):
  - beq: op 000100.
  - bne: op 000101.
  - j: op 000010.
  - jal: op 000011.
  - jr: op 000000 with funct 001000.
  - Every other encoding is not a control transfer.
- Target computation, all 32-bit modulo arithmetic:
  - beq/bne: `pc_id + 4 + (sign_extend(imm16) << 2)`.
  - j/jal: `{pc_id_plus4[31:28], instr_id[25:0], 2'b00}`.
  - jr: `rs_val`.
- Taken condition:
  - beq: `rs_val == rt_val`.
  - bne: `rs_val != rt_val`.
  - j/jal/jr: always taken.
- `Jumpsign` = taken AND NOT `stall`. `JumpAddr` = computed target; it is don't-care when `Jumpsign`=0 but is still driven deterministically.
- `link_id` = `pc_id + 8` always, with 32-bit wrap.
- `taken_cnt` increments by 1 on each edge where `Jumpsign`=1 and `reset`=0. It wraps at 2^CNT_W−1 to 0.
- Delay slot:
  - No flush exists. The instruction fetched in the cycle `Jumpsign`=1 enters ID next and carries `ds_id`=1.
  - A control transfer sitting in a delay slot is still resolved normally (no special case).

## Timing
- Redirect is combinational from IF/ID state and `rs_val`/`rt_val`. The PC register loads `JumpAddr` on the same edge that moves the delay slot into ID. Redirect latency from branch entering ID to target fetched is 1 cycle.
- IF/ID capture latency: 1 cycle.
- Stall mid-branch: `Jumpsign` stays 0 for every stalled cycle and the branch remains in ID. It resolves in the first cycle with `stall`=0, using the current operands. The counter increments exactly once per branch.
- `reset` and `stall` high together: reset wins.
- Reset with a branch in ID: `Jumpsign` is 0 in the cycle after the edge (nop in ID).
- `Jumpsign` is never asserted while `reset` has just cleared the register; the first legal assertion is after a valid fetch is captured.

## Test plan
- Reset: assert `reset` 2 cycles with `stall`=1. Required: `instr_id`=0, `pc_id`=0x3000, `ds_id`=0, `taken_cnt`=0, `Jumpsign`=0.
- beq taken: `PC`=0x3004, `instr_if`=0x1085_0003, next cycle `rs_val`=`rt_val`=5. Required: `Jumpsign`=1, `JumpAddr`=0x3014, `taken_cnt`=1. Next captured instruction has `ds_id`=1.
- bne not taken: same encoding with op 000101, `rs_val`=`rt_val`=7. Required: `Jumpsign`=0, `taken_cnt` unchanged, following `ds_id`=1.
- jal/jr: jal 0x0C00_0C10 at `pc_id`=0x3008. Required: `JumpAddr`=0x0000_3040, `link_id`=0x3010. Then jr 0x03E0_0008 with `rs_val`=0x3010. Required: `JumpAddr`=0x3010.
- Stall hold: beq taken in ID with `stall`=1 for 3 cycles. Required: `Jumpsign`=0 throughout and IF/ID unchanged. When `stall`=0: `Jumpsign`=1 for one cycle and `taken_cnt` rises by exactly 1.
- Wrap: `CNT_W`=4 with 16 taken jumps. Required: `taken_cnt`=0. Also `pc_id`=0xFFFF_FFFC yields `link_id`=0x0000_0004.
